trace_recorder: RTL
===================

# trace_recorder

Captures the TinyRV1 processor's per-instruction commit trace into an on-chip FIFO and presents it to a downstream consumer over a val/rdy read port. It sits beside the processor: the processor drives the trace bus and the recorder consumes it. A debug unit, bus bridge or test bench drains entries in commit order without stalling the processor. Overflow is counted, never back-pressured.

## Interface

- DEPTH, 16, number of entries; power of two, 2..256
- DROP_W, 16, width of the dropped-entry counter
- clk  in  1  clock, all state updated on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of FIFO, overflow and drop counter
- trace_val  in  1  one instruction committed this cycle
- trace_addr  in  32  PC of committed instruction
- trace_inst  in  32  instruction word
- trace_wen  in  1  instruction writes a register
- trace_wreg  in  5  destination register
- trace_wdata  in  32  value written
- rd_val  out  1  head entry valid
- rd_rdy  in  1  consumer accepts head entry
- rd_addr, rd_inst, rd_wdata  out  32 each  head entry fields
- rd_wen  out  1, rd_wreg  out  5  head entry fields
- count  out  $clog2(DEPTH)+1  occupied entries
- overflow  out  1  sticky: at least one entry dropped
- drop_count  out  DROP_W  dropped entries, saturating

## Operation

- Push when trace_val=1 and (not full, or full and pop in same cycle).
- Pop when rd_val=1 and rd_rdy=1; rd_* show head entry, stable while rd_val=1 and rd_rdy=0.
- Normalization on push: trace_wen=0 stores wreg=0, wdata=0; trace_wen=1 and trace_wreg=0 stores wdata=0.
- Full and trace_val=1 without pop: entry dropped, overflow<=1, drop_count increments, saturating at all ones.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count tracks occupancy 0..DEPTH.
- clr=1 has priority over push and pop: count, pointers, overflow and drop_count go to 0. A trace_val in the same cycle is discarded and not counted.
- No state machine beyond FIFO occupancy; full = (count==DEPTH), empty = (count==0).

## Timing

- Reset (rst_n=0, async): rd_val=0, count=0, overflow=0, drop_count=0; rd_* data outputs 0.
- Push-to-visible latency 1 cycle: entry pushed at edge N drives rd_val=1 after edge N.
- No bypass when empty: same-cycle push and rd_rdy do not pop.
- Pop takes effect at the edge; next head is visible after that edge. Throughput is 1 push and 1 pop per cycle.
- Full with push and pop in the same cycle: both occur, count stays DEPTH, no drop.
- Reset asserted mid-stream discards all entries immediately; the first push after deassert lands in slot 0.

## Configuration

- TRACE_RECORDER_CYCLE_STAMP_EN defined:
  - A free-running 32-bit cycle counter runs, reset to 0 and wrapping; clr does not affect it.
  - Each pushed entry stores the counter value at push, output on the extra port rd_cycle (out, 32).
- Undefined: no counter and no rd_cycle port; entry storage is 102 bits.

## Structure

- Package trace_recorder_pkg holds:
  - typedef trace_entry_t: packed struct with addr, inst, wen, wreg, wdata, and cycle under the macro.
  - function normalize_entry.
- Sub-module trace_recorder_fifo: parameterized trace_entry_t storage with pointers, count, and full/empty.
- The top level adds normalization, drop accounting and the optional stamp.

## Test plan

- Reset, then push addr=0x200 inst=0x00100093 (addi x1,x0,1) wen=1 wreg=1 wdata=1 -> next cycle rd_val=1 with exactly those fields, count=1.
- Push wen=1 wreg=0 wdata=0xdeadbeef, then wen=0 wdata=0x1234 -> popped entries have wdata=0 and wreg=0.
- DEPTH=16: push 20 entries with rd_rdy=0 -> count=16, overflow=1, drop_count=4; pops return the first 16 addrs 0x200..0x23c in order.
- Full FIFO, trace_val=1 and rd_rdy=1 in the same cycle -> count stays 16, drop_count unchanged, tail holds the new addr.
- Hold rd_rdy=0 for 5 cycles with rd_val=1 -> rd_* unchanged; then clr=1 together with trace_val=1 -> count=0, overflow=0, rd_val=0 next cycle.
- With TRACE_RECORDER_CYCLE_STAMP_EN, push at cycles 3 and 7 after reset release -> rd_cycle reads 3 then 7; rst_n pulled low mid-stream -> rd_val=0 immediately.

Source files
------------

// File: rtl/trace_recorder_pkg.sv
// Shared entry type and normalization for the TinyRV1 commit-trace recorder.
// Build option: TRACE_RECORDER_CYCLE_STAMP_EN adds a 32-bit cycle stamp field.
package trace_recorder_pkg;

    typedef struct packed {
`ifdef TRACE_RECORDER_CYCLE_STAMP_EN
        logic [31:0] cycle;
`endif
        logic [31:0] addr;
        logic [31:0] inst;
        logic        wen;
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } trace_entry_t;

    // Non-writing instructions carry no destination; writes to x0 carry no data.
    function automatic trace_entry_t normalize_entry(input trace_entry_t e);
        trace_entry_t n;
        n = e;
        if (!e.wen) begin
            n.wreg  = '0;
            n.wdata = '0;
        end else if (e.wreg == 5'd0) begin
            n.wdata = '0;
        end
        return n;
    endfunction

endpackage

// File: rtl/trace_recorder_if.sv
// Commit-trace bus plus val/rdy read port; the recorder is the slave side.
interface trace_recorder_if;

    logic        trace_val;
    logic [31:0] trace_addr;
    logic [31:0] trace_inst;
    logic        trace_wen;
    logic [4:0]  trace_wreg;
    logic [31:0] trace_wdata;

    logic        rd_val;
    logic        rd_rdy;
    logic [31:0] rd_addr;
    logic [31:0] rd_inst;
    logic        rd_wen;
    logic [4:0]  rd_wreg;
    logic [31:0] rd_wdata;
`ifdef TRACE_RECORDER_CYCLE_STAMP_EN
    logic [31:0] rd_cycle;
`endif

    modport master (
        output trace_val, trace_addr, trace_inst, trace_wen, trace_wreg, trace_wdata,
        output rd_rdy,
`ifdef TRACE_RECORDER_CYCLE_STAMP_EN
        input  rd_cycle,
`endif
        input  rd_val, rd_addr, rd_inst, rd_wen, rd_wreg, rd_wdata
    );

    modport slave (
        input  trace_val, trace_addr, trace_inst, trace_wen, trace_wreg, trace_wdata,
        input  rd_rdy,
`ifdef TRACE_RECORDER_CYCLE_STAMP_EN
        output rd_cycle,
`endif
        output rd_val, rd_addr, rd_inst, rd_wen, rd_wreg, rd_wdata
    );

endinterface

// File: rtl/trace_recorder_fifo.sv
// Circular buffer of trace entries with wrap-around pointers and occupancy count.
module trace_recorder_fifo
    import trace_recorder_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  trace_entry_t           wr_entry,
    output trace_entry_t           rd_entry,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    trace_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign rd_entry = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/trace_recorder.sv
// Records TinyRV1 commit trace into a FIFO; overflow is counted, never back-pressured.
// Build option: TRACE_RECORDER_CYCLE_STAMP_EN stamps entries and adds rd_cycle.
module trace_recorder
    import trace_recorder_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    trace_recorder_if.slave        tr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);

    trace_entry_t      raw_entry, wr_entry, rd_entry;
    logic              full, empty, push, pop, drop;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
`ifdef TRACE_RECORDER_CYCLE_STAMP_EN
    logic [31:0]       cycle_q, cycle_d;
`endif

    // Pop is checked first so a full FIFO can accept while draining.
    assign pop  = !empty && tr.rd_rdy && !clr;
    assign push = tr.trace_val && !clr && (!full || pop);
    assign drop = tr.trace_val && !clr && full && !pop;

    always_comb begin
        raw_entry       = '0;
        raw_entry.addr  = tr.trace_addr;
        raw_entry.inst  = tr.trace_inst;
        raw_entry.wen   = tr.trace_wen;
        raw_entry.wreg  = tr.trace_wreg;
        raw_entry.wdata = tr.trace_wdata;
`ifdef TRACE_RECORDER_CYCLE_STAMP_EN
        raw_entry.cycle = cycle_q;
`endif
    end

    assign wr_entry = normalize_entry(raw_entry);

    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (clr) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end else if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != '1) drop_count_d = drop_count_q + DROP_W'(1);
        end
`ifdef TRACE_RECORDER_CYCLE_STAMP_EN
        cycle_d = cycle_q + 32'd1;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
`ifdef TRACE_RECORDER_CYCLE_STAMP_EN
            cycle_q      <= '0;
`endif
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
`ifdef TRACE_RECORDER_CYCLE_STAMP_EN
            cycle_q      <= cycle_d;
`endif
        end
    end

    trace_recorder_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .push     (push),
        .pop      (pop),
        .wr_entry (wr_entry),
        .rd_entry (rd_entry),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign tr.rd_val   = !empty;
    assign tr.rd_addr  = rd_entry.addr;
    assign tr.rd_inst  = rd_entry.inst;
    assign tr.rd_wen   = rd_entry.wen;
    assign tr.rd_wreg  = rd_entry.wreg;
    assign tr.rd_wdata = rd_entry.wdata;
`ifdef TRACE_RECORDER_CYCLE_STAMP_EN
    assign tr.rd_cycle = rd_entry.cycle;
`endif
    assign overflow    = overflow_q;
    assign drop_count  = drop_count_q;

endmodule
